// File: rtl/ifu_line_fetch.sv
// Instruction fetch front end: serves 32-bit fetches from a one-line buffer and
// refills it over an AR/R read channel, one transaction outstanding at a time.
module ifu_line_fetch #(
  parameter int DW = 128,
  parameter int AW = 16,
  parameter int IW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          reqValid,
  output logic          reqReady,
  input  logic [AW-1:0] reqAddr,
  input  logic          flush,
  output logic          respValid,
  input  logic          respReady,
  output logic [IW-1:0] respInst,
  output logic          arValid,
  input  logic          arReady,
  output logic [AW-1:0] arAddr,
  input  logic          rValid,
  output logic          rReady,
  input  logic [DW-1:0] rData
);

  localparam int BW = $clog2(DW >> 3);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] AR   = 2'd1;
  localparam logic [1:0] R    = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]     state_q, state_d;
  logic [AW-1:2]  addr_q, addr_d;
  logic [DW-1:0]  line_q, line_d;
  logic [AW-1:BW] tag_q, tag_d;
  logic           line_valid_q, line_valid_d;
  logic           drop_q, drop_d;
  logic           hit;

  // Instructions are word aligned; the two low address bits carry no information.
  logic unused_addr_bits;
  assign unused_addr_bits = ^reqAddr[1:0];

  assign hit       = line_valid_q && (tag_q == reqAddr[AW-1:BW]);
  assign reqReady  = (state_q == IDLE) && !flush;
  assign arValid   = (state_q == AR);
  assign rReady    = (state_q == R);
  assign respValid = (state_q == RESP);
  assign arAddr    = {addr_q[AW-1:BW], {BW{1'b0}}};
  assign respInst  = line_q[addr_q[BW-1:2]*IW +: IW];

  always_comb begin
    // NOTE: every next-state signal takes its held value first so no path leaves it unassigned (no latch).
    state_d      = state_q;
    addr_d       = addr_q;
    line_d       = line_q;
    tag_d        = tag_q;
    line_valid_d = line_valid_q;
    drop_d       = drop_q;

    case (state_q)
      IDLE: begin
        if (reqValid && reqReady) begin
          addr_d  = reqAddr[AW-1:2];
          state_d = hit ? RESP : AR;
        end
      end
      AR: begin
        // A flushed address phase still completes; its data beat is discarded later.
        if (flush)   drop_d  = 1'b1;
        if (arReady) state_d = R;
      end
      R: begin
        if (flush) drop_d = 1'b1;
        if (rValid) begin
          if (drop_q || flush) begin
            drop_d  = 1'b0;
            state_d = IDLE;
          end else begin
            line_d       = rData;
            tag_d        = addr_q[AW-1:BW];
            line_valid_d = 1'b1;
            state_d      = RESP;
          end
        end
      end
      RESP: begin
        if (flush || respReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (flush) line_valid_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      line_q       <= '0;
      tag_q        <= '0;
      line_valid_q <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state_q      <= state_d;
      addr_q       <= addr_d;
      line_q       <= line_d;
      tag_q        <= tag_d;
      line_valid_q <= line_valid_d;
      drop_q       <= drop_d;
    end
  end

endmodule
